// File: rtl/alu_pkg.sv
// Shared opcode/function codes, FSM state encoding and constants for the sequential ALU.
package alu_pkg;

    localparam logic [1:0] OP_ARITH = 2'd0;
    localparam logic [1:0] OP_CMP   = 2'd1;
    localparam logic [1:0] OP_LOGIC = 2'd2;
    localparam logic [1:0] OP_SHIFT = 2'd3;

    localparam logic [1:0] FN_SLT = 2'b10;
    localparam logic [1:0] FN_MV  = 2'b11;
    localparam logic [1:0] FN_ORR = 2'b00;
    localparam logic [1:0] FN_SUB = 2'b01;
    localparam logic [1:0] FN_SLL = 2'b00;
    localparam logic [1:0] FN_SRL = 2'b01;

    // Value MV produces for its special immediate code, sign-extended by the user.
    localparam int MV_NEG_VAL = -7;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/alu_shift_unit.sv
// Iterative one-bit-per-cycle shifter: down-counts the shift amount and flags the final step.
module alu_shift_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             active,
    input  logic             dir,
    input  logic [WIDTH-1:0] data_in,
    input  logic [CNT_W-1:0] amount,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] work_q, work_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] shifted;

    always_comb begin
        shifted = dir_q ? (work_q >> 1) : (work_q << 1);
        // The last step is the one whose shifted value goes straight to the output register.
        done    = active && (cnt_q == CNT_W'(1));
        result  = shifted;
        work_d  = work_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        if (start) begin
            work_d = data_in;
            cnt_d  = amount;
            dir_d  = dir;
        end else if (active) begin
            work_d = shifted;
            cnt_d  = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q <= '0;
            cnt_q  <= '0;
            dir_q  <= 1'b0;
        end else begin
            work_q <= work_d;
            cnt_q  <= cnt_d;
            dir_q  <= dir_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle decode/datapath, iterative shifts, registered result and flags.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int IMM_W       = 3,
    parameter int MV_NEG_CODE = 2
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] InputA,
    input  logic [WIDTH-1:0] InputB,
    input  logic [IMM_W-1:0] Immediate,
    input  logic [1:0]       OP,
    input  logic [1:0]       Function,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Out,
    output logic             Zero,
    output logic             Negative,
    output logic             Carry,
    output logic             Illegal,
    output logic             Busy
);

    localparam int               CNT_W   = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] W_LIMIT = WIDTH'(WIDTH);
    localparam logic [WIDTH-1:0] MV_NEG  = WIDTH'(MV_NEG_VAL);
    localparam logic [IMM_W-1:0] MV_CODE = IMM_W'(MV_NEG_CODE);

    state_t           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             carry_q, carry_d;
    logic             illegal_q, illegal_d;

    logic             accept, load, sh_start, sh_done;
    logic [WIDTH-1:0] sh_result;
    logic             dec_shift, dec_dir, dec_carry, dec_illegal, slt;
    logic [WIDTH-1:0] dec_res, load_res;
    logic [WIDTH:0]   sum_add, sum_sub;

    always_comb begin
        sum_add     = {1'b0, InputA} + {1'b0, InputB};
        // Carry out of A + ~B + 1 is the "no borrow" flag.
        sum_sub     = {1'b0, InputA} + {1'b0, ~InputB} + {{WIDTH{1'b0}}, 1'b1};
        slt         = $signed(InputA) < $signed(InputB);
        dec_res     = '0;
        dec_carry   = 1'b0;
        dec_illegal = 1'b0;
        dec_shift   = 1'b0;
        dec_dir     = 1'b0;
        case (OP)
            OP_ARITH: begin
                if (Function[0]) begin
                    dec_res   = sum_sub[WIDTH-1:0];
                    dec_carry = sum_sub[WIDTH];
                end else begin
                    dec_res   = sum_add[WIDTH-1:0];
                    dec_carry = sum_add[WIDTH];
                end
            end
            OP_CMP: begin
                case (Function)
                    FN_SLT:  dec_res = {{(WIDTH-1){1'b0}}, slt};
                    FN_MV:   dec_res = (Immediate == MV_CODE) ? MV_NEG
                                       : {{(WIDTH-IMM_W){1'b0}}, Immediate};
                    default: dec_illegal = 1'b1;
                endcase
            end
            OP_LOGIC: begin
                case (Function)
                    FN_ORR: dec_res = InputA | InputB;
                    FN_SUB: begin
                        dec_res   = sum_sub[WIDTH-1:0];
                        dec_carry = sum_sub[WIDTH];
                    end
                    default: dec_illegal = 1'b1;
                endcase
            end
            default: begin
                if (Function == FN_SLL || Function == FN_SRL) begin
                    dec_dir = (Function == FN_SRL);
                    if (InputB == '0)            dec_res   = InputA;
                    else if (InputB >= W_LIMIT)  dec_res   = '0;
                    else                         dec_shift = 1'b1;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        InReady = (state_q == ST_IDLE) && (!out_valid_q || OutReady);
        Busy    = (state_q == ST_SHIFT);
    end

    assign accept   = InValid && InReady;
    assign sh_start = accept && dec_shift;
    assign load     = (accept && !dec_shift) || sh_done;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (sh_start) state_d = ST_SHIFT;
            ST_SHIFT: if (sh_done)  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    alu_shift_unit #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_shift (
        .clk     (Clk),
        .rst_n   (Reset_n),
        .start   (sh_start),
        .active  (Busy),
        .dir     (dec_dir),
        .data_in (InputA),
        .amount  (InputB[CNT_W-1:0]),
        .done    (sh_done),
        .result  (sh_result)
    );

    always_comb begin
        load_res    = sh_done ? sh_result : dec_res;
        out_d       = out_q;
        zero_d      = zero_q;
        neg_d       = neg_q;
        carry_d     = carry_q;
        illegal_d   = illegal_q;
        out_valid_d = out_valid_q && !OutReady;
        if (load) begin
            out_valid_d = 1'b1;
            out_d       = load_res;
            zero_d      = (load_res == '0);
            neg_d       = load_res[WIDTH-1];
            carry_d     = sh_done ? 1'b0 : dec_carry;
            illegal_d   = sh_done ? 1'b0 : dec_illegal;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            carry_q     <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
            carry_q     <= carry_d;
            illegal_q   <= illegal_d;
        end
    end

    assign OutValid = out_valid_q;
    assign Out      = out_q;
    assign Zero     = zero_q;
    assign Negative = neg_q;
    assign Carry    = carry_q;
    assign Illegal  = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed, self-checking bench for alu_seq at WIDTH=8.
module tb_alu_seq;

    logic       Clk, Reset_n, InValid, InReady, OutValid, OutReady;
    logic [7:0] InputA, InputB, Out;
    logic [2:0] Immediate;
    logic [1:0] OP, Function;
    logic       Zero, Negative, Carry, Illegal, Busy;

    int errors = 0;
    int checks = 0;

    alu_seq #(.WIDTH(8), .IMM_W(3), .MV_NEG_CODE(2)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .InValid(InValid), .InReady(InReady),
        .InputA(InputA), .InputB(InputB), .Immediate(Immediate), .OP(OP),
        .Function(Function), .OutValid(OutValid), .OutReady(OutReady), .Out(Out),
        .Zero(Zero), .Negative(Negative), .Carry(Carry), .Illegal(Illegal), .Busy(Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Presents one request for exactly one clock edge.
    task automatic drive(input logic [1:0] op, input logic [1:0] fn,
                         input logic [7:0] a, input logic [7:0] b, input logic [2:0] imm);
        OP = op; Function = fn; InputA = a; InputB = b; Immediate = imm;
        InValid = 1'b1;
        step();
        InValid = 1'b0;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0; InValid = 1'b0; OutReady = 1'b1;
        OP = 2'd0; Function = 2'd0; InputA = 8'h00; InputB = 8'h00; Immediate = 3'd0;
        #12;
        checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL reset_outvalid got=%b exp=0", OutValid); end
        checks++; if ({Out, Zero, Negative, Carry, Illegal, Busy} !== 13'h0) begin errors++;
            $display("FAIL reset_outputs got=%h %b%b%b%b%b exp=00 00000", Out, Zero, Negative, Carry, Illegal, Busy); end
        step();
        Reset_n = 1'b1;
        #1;
        checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL reset_inready got=%b exp=1", InReady); end
    endtask

    task automatic test_add();
        drive(2'd0, 2'b00, 8'hFF, 8'h01, 3'd0);
        checks++; if (OutValid !== 1'b1) begin errors++; $display("FAIL add_valid got=%b exp=1", OutValid); end
        checks++; if ({Out, Zero, Carry, Negative} !== {8'h00, 3'b110}) begin errors++;
            $display("FAIL add_ff_01 got=%h z%b c%b n%b exp=00 z1 c1 n0", Out, Zero, Carry, Negative); end
        step();
        checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL add_drain got=%b exp=0", OutValid); end
    endtask

    task automatic test_sub_beq();
        drive(2'd0, 2'b01, 8'h05, 8'h05, 3'd0);
        checks++; if ({Out, Zero, Carry} !== {8'h00, 2'b11}) begin errors++;
            $display("FAIL beq_equal got=%h z%b c%b exp=00 z1 c1", Out, Zero, Carry); end
        drive(2'd0, 2'b01, 8'h01, 8'h02, 3'd0);
        checks++; if ({Out, Zero, Carry, Negative} !== {8'hFF, 3'b001}) begin errors++;
            $display("FAIL beq_borrow got=%h z%b c%b n%b exp=ff z0 c0 n1", Out, Zero, Carry, Negative); end
        drive(2'd2, 2'b00, 8'hA0, 8'h05, 3'd0);
        checks++; if ({Out, Carry} !== {8'hA5, 1'b0}) begin errors++;
            $display("FAIL orr got=%h c%b exp=a5 c0", Out, Carry); end
    endtask

    task automatic test_slt();
        drive(2'd1, 2'b10, 8'hFE, 8'h03, 3'd0);
        checks++; if (Out !== 8'h01) begin errors++; $display("FAIL slt_neg got=%h exp=01", Out); end
        drive(2'd1, 2'b10, 8'h04, 8'h03, 3'd0);
        checks++; if (Out !== 8'h00) begin errors++; $display("FAIL slt_gt got=%h exp=00", Out); end
        drive(2'd1, 2'b10, 8'h06, 8'h06, 3'd0);
        checks++; if (Out !== 8'h00) begin errors++; $display("FAIL slt_eq got=%h exp=00", Out); end
    endtask

    task automatic test_mv();
        drive(2'd1, 2'b11, 8'h00, 8'h00, 3'b010);
        checks++; if ({Out, Negative} !== {8'hF9, 1'b1}) begin errors++;
            $display("FAIL mv_neg got=%h n%b exp=f9 n1", Out, Negative); end
        drive(2'd1, 2'b11, 8'h00, 8'h00, 3'b111);
        checks++; if ({Out, Negative} !== {8'h07, 1'b0}) begin errors++;
            $display("FAIL mv_pos got=%h n%b exp=07 n0", Out, Negative); end
    endtask

    task automatic test_illegal();
        drive(2'd1, 2'b00, 8'h12, 8'h34, 3'd0);
        checks++; if ({OutValid, Out, Illegal} !== {1'b1, 8'h00, 1'b1}) begin errors++;
            $display("FAIL illegal got=v%b %h i%b exp=v1 00 i1", OutValid, Out, Illegal); end
        drive(2'd0, 2'b00, 8'h01, 8'h02, 3'd0);
        checks++; if ({Out, Illegal} !== {8'h03, 1'b0}) begin errors++;
            $display("FAIL illegal_clear got=%h i%b exp=03 i0", Out, Illegal); end
    endtask

    task automatic test_shift();
        int busy_cnt;
        int cyc;
        drive(2'd3, 2'b00, 8'h04, 8'h03, 3'd0);
        checks++; if ({Busy, InReady} !== 2'b10) begin errors++;
            $display("FAIL sll_busy got=b%b r%b exp=b1 r0", Busy, InReady); end
        busy_cnt = 0; cyc = 0;
        while (OutValid !== 1'b1 && cyc < 20) begin
            if (Busy === 1'b1) busy_cnt++;
            step();
            cyc++;
        end
        checks++; if (busy_cnt != 3) begin errors++; $display("FAIL sll_latency got=%0d exp=3", busy_cnt); end
        checks++; if ({Out, Busy, Carry} !== {8'h20, 2'b00}) begin errors++;
            $display("FAIL sll_result got=%h b%b c%b exp=20 b0 c0", Out, Busy, Carry); end

        drive(2'd3, 2'b01, 8'h04, 8'h09, 3'd0);
        checks++; if ({OutValid, Out, Zero, Busy} !== {1'b1, 8'h00, 1'b1, 1'b0}) begin errors++;
            $display("FAIL srl_fast got=v%b %h z%b b%b exp=v1 00 z1 b0", OutValid, Out, Zero, Busy); end

        drive(2'd3, 2'b00, 8'h5A, 8'h00, 3'd0);
        checks++; if ({OutValid, Out} !== {1'b1, 8'h5A}) begin errors++;
            $display("FAIL sll_zero got=v%b %h exp=v1 5a", OutValid, Out); end

        drive(2'd3, 2'b01, 8'h80, 8'h07, 3'd0);
        busy_cnt = 0; cyc = 0;
        while (OutValid !== 1'b1 && cyc < 20) begin
            if (Busy === 1'b1) busy_cnt++;
            step();
            cyc++;
        end
        checks++; if (busy_cnt != 7) begin errors++; $display("FAIL srl7_latency got=%0d exp=7", busy_cnt); end
        checks++; if (Out !== 8'h01) begin errors++; $display("FAIL srl7_result got=%h exp=01", Out); end
    endtask

    task automatic test_back_to_back();
        step();
        OutReady = 1'b0;
        drive(2'd2, 2'b01, 8'h04, 8'h01, 3'd0);
        for (int i = 0; i < 4; i++) begin
            checks++; if ({OutValid, Out, Carry, InReady} !== {1'b1, 8'h03, 1'b1, 1'b0}) begin errors++;
                $display("FAIL hold_%0d got=v%b %h c%b r%b exp=v1 03 c1 r0", i, OutValid, Out, Carry, InReady); end
            step();
        end
        OutReady = 1'b1;
        OP = 2'd0; Function = 2'b00; InputA = 8'h02; InputB = 8'h03; InValid = 1'b1;
        #1;
        checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL drain_accept_ready got=%b exp=1", InReady); end
        @(posedge Clk);
        #1;
        InValid = 1'b0;
        checks++; if ({OutValid, Out} !== {1'b1, 8'h05}) begin errors++;
            $display("FAIL back_to_back got=v%b %h exp=v1 05", OutValid, Out); end
        step();
        checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%b exp=0", OutValid); end
    endtask

    task automatic test_reset_mid_shift();
        drive(2'd0, 2'b00, 8'hFF, 8'hFF, 3'd0);
        drive(2'd3, 2'b00, 8'h01, 8'h05, 3'd0);
        step();
        checks++; if ({Busy, Out, Carry, Negative} !== {1'b1, 8'hFE, 2'b11}) begin errors++;
            $display("FAIL pre_reset got=b%b %h c%b n%b exp=b1 fe c1 n1", Busy, Out, Carry, Negative); end
        Reset_n = 1'b0;
        #1;
        checks++; if ({OutValid, Out, Zero, Negative, Carry, Illegal, Busy} !== 14'h0) begin errors++;
            $display("FAIL mid_reset got=v%b %h %b%b%b%b%b exp=v0 00 00000", OutValid, Out, Zero, Negative, Carry, Illegal, Busy); end
        #2;
        Reset_n = 1'b1;
        step();
        checks++; if ({OutValid, Busy, InReady} !== 3'b001) begin errors++;
            $display("FAIL post_reset got=v%b b%b r%b exp=v0 b0 r1", OutValid, Busy, InReady); end
        drive(2'd0, 2'b00, 8'h01, 8'h01, 3'd0);
        checks++; if ({OutValid, Out} !== {1'b1, 8'h02}) begin errors++;
            $display("FAIL post_reset_add got=v%b %h exp=v1 02", OutValid, Out); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_beq();
        test_slt();
        test_mv();
        test_illegal();
        test_shift();
        test_back_to_back();
        test_reset_mid_shift();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
